// File: rtl/cim_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cim_pkg
// Description : Shared definitions for the CiM MAC sequencer. Holds the
//               default macro geometry, the derivations of the macro output
//               width and the accumulator width, and the sequencer state
//               encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package cim_pkg;

    // Default geometry of the tsmccim16x8x11m1 macro
    localparam int CORE_NUM_DEF      = 16;
    localparam int XIN_BIT_WIDTH_DEF = 11;
    localparam int MEM_BIT_WIDTH_DEF = 8;
    localparam int MEM_ADR_WIDTH_DEF = 2;
    localparam int MACRO_LAT_DEF     = 1;

    // Width of the macro Q bus: product width plus growth from summing cores
    function automatic int calc_output_width(input int xin_w, input int mem_w, input int core_num);
        return xin_w + mem_w - 1 + $clog2(core_num);
    endfunction

    // Accumulator width: one bit of growth per address bit covers the
    // worst case of summing every row of the macro.
    function automatic int calc_acc_width(input int out_w, input int adr_w);
        return out_w + adr_w;
    endfunction

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        STROBE = 3'd2,
        WAIT   = 3'd3,
        DONE   = 3'd4
    } state_e;

endpackage
`default_nettype wire

// File: rtl/cim_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cim_mac_sequencer
// Description : Compute sequencer and partial-sum accumulator for the CiM
//               macro. Accepts a job (START/NUM_ROWS/BANK_CFG), consumes one
//               XIN activation vector per weight row, strobes the macro read
//               compute once per row, sign-extends and accumulates the Q
//               partial sums and returns the total on a valid/ready port.
// Ports       : CLK, NRST               - clock, async active-low reset
//               START/NUM_ROWS/BANK_CFG - job command; BUSY, ERR status
//               XIN_VALID/READY/DATA    - activation vector stream
//               M_ENCB/M_REB/M_BANKB/M_ADRB/M_XIN/M_Q - macro compute side
//               RES_VALID/READY/DATA    - accumulated result
// Revision    : 1.0 - initial release
// ============================================================================
module cim_mac_sequencer
    import cim_pkg::*;
#(
    parameter int CORE_NUM         = CORE_NUM_DEF,
    parameter int XIN_BIT_WIDTH    = XIN_BIT_WIDTH_DEF,
    parameter int MEM_BIT_WIDTH    = MEM_BIT_WIDTH_DEF,
    parameter int MEM_ADR_WIDTH    = MEM_ADR_WIDTH_DEF,
    parameter int MACRO_LAT        = MACRO_LAT_DEF,
    // Derived widths; leave at their defaults
    parameter int OUTPUT_BIT_WIDTH = calc_output_width(XIN_BIT_WIDTH, MEM_BIT_WIDTH, CORE_NUM),
    parameter int ACC_W            = calc_acc_width(OUTPUT_BIT_WIDTH, MEM_ADR_WIDTH)
) (
    input  logic                              CLK,
    input  logic                              NRST,
    input  logic                              START,
    input  logic [MEM_ADR_WIDTH:0]            NUM_ROWS,
    input  logic [$clog2(CORE_NUM)-1:0]       BANK_CFG,
    output logic                              BUSY,
    output logic                              ERR,
    input  logic                              XIN_VALID,
    output logic                              XIN_READY,
    input  logic [CORE_NUM*XIN_BIT_WIDTH-1:0] XIN_DATA,
    output logic                              M_ENCB,
    output logic                              M_REB,
    output logic [$clog2(CORE_NUM)-1:0]       M_BANKB,
    output logic [MEM_ADR_WIDTH-1:0]          M_ADRB,
    output logic [CORE_NUM*XIN_BIT_WIDTH-1:0] M_XIN,
    input  logic [OUTPUT_BIT_WIDTH-1:0]       M_Q,
    output logic                              RES_VALID,
    input  logic                              RES_READY,
    output logic [ACC_W-1:0]                  RES_DATA
);

    localparam int                   BANK_W   = $clog2(CORE_NUM);
    localparam int                   XIN_W    = CORE_NUM * XIN_BIT_WIDTH;
    localparam int                   LAT_W    = $clog2(MACRO_LAT + 1);
    localparam logic [LAT_W-1:0]     LAT_LAST = LAT_W'(MACRO_LAT - 1);
    localparam logic [MEM_ADR_WIDTH:0] MAX_ROWS = {1'b1, {MEM_ADR_WIDTH{1'b0}}};
    localparam logic [MEM_ADR_WIDTH:0] ONE_ROW  = (MEM_ADR_WIDTH + 1)'(1);

    state_e                     state_q,     state_d;
    logic [MEM_ADR_WIDTH:0]     num_rows_q,  num_rows_d;
    logic [MEM_ADR_WIDTH-1:0]   row_q,       row_d;
    logic [LAT_W-1:0]           lat_cnt_q,   lat_cnt_d;
    logic [ACC_W-1:0]           acc_q,       acc_d;
    logic [BANK_W-1:0]          bank_q,      bank_d;
    logic [MEM_ADR_WIDTH-1:0]   adr_q,       adr_d;
    logic [XIN_W-1:0]           xin_q,       xin_d;
    logic                       strobe_n_q,  strobe_n_d;
    logic                       xin_ready_q, xin_ready_d;
    logic                       busy_q,      busy_d;
    logic                       err_q,       err_d;
    logic                       res_valid_q, res_valid_d;
    logic [ACC_W-1:0]           res_data_q,  res_data_d;

    logic [ACC_W-1:0]           q_ext;
    logic [MEM_ADR_WIDTH:0]     last_row;

    // ACC_W exceeds the Q width by MEM_ADR_WIDTH bits of sign
    assign q_ext    = {{(ACC_W - OUTPUT_BIT_WIDTH){M_Q[OUTPUT_BIT_WIDTH-1]}}, M_Q};
    assign last_row = num_rows_q - ONE_ROW;

    always_comb begin
        state_d     = state_q;
        num_rows_d  = num_rows_q;
        row_d       = row_q;
        lat_cnt_d   = lat_cnt_q;
        acc_d       = acc_q;
        bank_d      = bank_q;
        adr_d       = adr_q;
        xin_d       = xin_q;
        strobe_n_d  = 1'b1;
        xin_ready_d = xin_ready_q;
        err_d       = 1'b0;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;

        case (state_q)
            IDLE: begin
                // Only IDLE looks at START; elsewhere it is ignored
                if (START) begin
                    if ((NUM_ROWS != '0) && (NUM_ROWS <= MAX_ROWS)) begin
                        state_d     = ISSUE;
                        num_rows_d  = NUM_ROWS;
                        bank_d      = BANK_CFG;
                        acc_d       = '0;
                        row_d       = '0;
                        xin_ready_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (XIN_VALID && xin_ready_q) begin
                    xin_d       = XIN_DATA;
                    adr_d       = row_q;
                    strobe_n_d  = 1'b0;
                    xin_ready_d = 1'b0;
                    state_d     = STROBE;
                end
            end
            STROBE: begin
                // Macro captures on the edge that leaves this state
                lat_cnt_d = '0;
                state_d   = WAIT;
            end
            WAIT: begin
                if (lat_cnt_q == LAT_LAST) begin
                    acc_d     = acc_q + q_ext;
                    lat_cnt_d = '0;
                    if ({1'b0, row_q} == last_row) begin
                        state_d = DONE;
                    end else begin
                        row_d       = row_q + MEM_ADR_WIDTH'(1);
                        xin_ready_d = 1'b1;
                        state_d     = ISSUE;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q + LAT_W'(1);
                end
            end
            DONE: begin
                // First DONE cycle publishes the final sum; then hold
                // until the consumer takes it.
                if (!res_valid_q) begin
                    res_valid_d = 1'b1;
                    res_data_d  = acc_q;
                end else if (RES_READY) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            state_q     <= IDLE;
            num_rows_q  <= '0;
            row_q       <= '0;
            lat_cnt_q   <= '0;
            acc_q       <= '0;
            bank_q      <= '0;
            adr_q       <= '0;
            xin_q       <= '0;
            strobe_n_q  <= 1'b1;
            xin_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            num_rows_q  <= num_rows_d;
            row_q       <= row_d;
            lat_cnt_q   <= lat_cnt_d;
            acc_q       <= acc_d;
            bank_q      <= bank_d;
            adr_q       <= adr_d;
            xin_q       <= xin_d;
            strobe_n_q  <= strobe_n_d;
            xin_ready_q <= xin_ready_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    // ENCB and REB are asserted together from one flop
    assign M_ENCB    = strobe_n_q;
    assign M_REB     = strobe_n_q;
    assign M_BANKB   = bank_q;
    assign M_ADRB    = adr_q;
    assign M_XIN     = xin_q;
    assign XIN_READY = xin_ready_q;
    assign BUSY      = busy_q;
    assign ERR       = err_q;
    assign RES_VALID = res_valid_q;
    assign RES_DATA  = res_data_q;

endmodule
`default_nettype wire

// File: tb/tb_cim_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cim_mac_sequencer
// Description : Directed self-checking bench for cim_mac_sequencer with a
//               behavioural macro model returning a per-row Q table.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cim_mac_sequencer;

    logic          CLK = 1'b0;
    logic          NRST;
    logic          START;
    logic [2:0]    NUM_ROWS;
    logic [3:0]    BANK_CFG;
    logic          BUSY;
    logic          ERR;
    logic          XIN_VALID;
    logic          XIN_READY;
    logic [175:0]  XIN_DATA;
    logic          M_ENCB;
    logic          M_REB;
    logic [3:0]    M_BANKB;
    logic [1:0]    M_ADRB;
    logic [175:0]  M_XIN;
    logic [21:0]   M_Q;
    logic          RES_VALID;
    logic          RES_READY;
    logic [23:0]   RES_DATA;

    int n_checks = 0;
    int n_fail   = 0;

    cim_mac_sequencer dut (
        .CLK       (CLK),
        .NRST      (NRST),
        .START     (START),
        .NUM_ROWS  (NUM_ROWS),
        .BANK_CFG  (BANK_CFG),
        .BUSY      (BUSY),
        .ERR       (ERR),
        .XIN_VALID (XIN_VALID),
        .XIN_READY (XIN_READY),
        .XIN_DATA  (XIN_DATA),
        .M_ENCB    (M_ENCB),
        .M_REB     (M_REB),
        .M_BANKB   (M_BANKB),
        .M_ADRB    (M_ADRB),
        .M_XIN     (M_XIN),
        .M_Q       (M_Q),
        .RES_VALID (RES_VALID),
        .RES_READY (RES_READY),
        .RES_DATA  (RES_DATA)
    );

    always #5 CLK = ~CLK;

    // Macro model: Q valid for exactly one cycle after the capture edge,
    // garbage otherwise, so a late or early sample picks up a wrong value.
    logic [21:0] q_tab [4];
    always @(posedge CLK or negedge NRST) begin
        if (!NRST)                  M_Q <= 22'h0;
        else if (!M_ENCB && !M_REB) M_Q <= q_tab[M_ADRB];
        else                        M_Q <= 22'h155555;
    end

    // Monitors: cycle count, handshakes, strobe cycles and what they carried
    int           cyc        = 0;
    int           hs_cnt     = 0;
    int           strobe_cnt = 0;
    int           bad_strobe = 0;
    int           err_cnt    = 0;
    logic [1:0]   adr_log  [256];
    logic [3:0]   bank_log [256];
    logic [175:0] xin_log  [256];

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (NRST && XIN_VALID && XIN_READY) hs_cnt <= hs_cnt + 1;
    end

    always @(negedge CLK) begin
        if (NRST && (!M_ENCB || !M_REB)) begin
            if (M_ENCB !== M_REB || hs_cnt <= strobe_cnt) bad_strobe <= bad_strobe + 1;
            adr_log[strobe_cnt[7:0]]  <= M_ADRB;
            bank_log[strobe_cnt[7:0]] <= M_BANKB;
            xin_log[strobe_cnt[7:0]]  <= M_XIN;
            strobe_cnt <= strobe_cnt + 1;
        end
        if (ERR === 1'b1) err_cnt <= err_cnt + 1;
    end

    function automatic logic [175:0] xin_pat(input int r);
        logic [10:0] v;
        v = 11'(r * 97 + 'h2A5);
        return {16{v}};
    endfunction

    // Job results
    int          hs_k;
    int          j_lat;
    logic [23:0] j_res;
    int          j_hold_bad;
    int          j_busy_bad;
    logic        j_busy_after;
    logic        j_busy_after2;
    logic        j_rv_after;

    task automatic run_job(input int rows, input logic [3:0] bank, input bit gaps,
                           input bit poke, input int ready_delay);
        int n;
        logic [23:0] snap;
        j_hold_bad = 0;
        j_busy_bad = 0;
        j_lat      = -1;
        j_res      = 'x;
        @(negedge CLK);
        START = 1'b1; NUM_ROWS = 3'(rows); BANK_CFG = bank;
        @(negedge CLK);
        START = 1'b0;
        for (int r = 0; r < rows; r++) begin
            if (gaps) repeat ($urandom_range(0, 3)) @(negedge CLK);
            XIN_VALID = 1'b1;
            XIN_DATA  = xin_pat(r);
            n = 0;
            while (XIN_READY !== 1'b1 && n < 60) begin
                @(negedge CLK);
                n++;
            end
            if (n >= 60) begin
                n_checks++; n_fail++;
                $display("FAIL xin_ready_timeout row=%0d got=%b want=1", r, XIN_READY);
                XIN_VALID = 1'b0;
                return;
            end
            if (BUSY !== 1'b1) j_busy_bad++;
            hs_k = cyc;
            @(negedge CLK);
            XIN_VALID = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
            if (poke) begin
                START = 1'b1; NUM_ROWS = 3'd0;
            end
            @(negedge CLK);
            START = 1'b0; XIN_VALID = 1'b0;
        end
        n = 0;
        while (RES_VALID !== 1'b1 && n < 60) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 60) begin
            n_checks++; n_fail++;
            $display("FAIL res_valid_timeout got=%b want=1", RES_VALID);
            return;
        end
        j_lat = cyc - hs_k;
        j_res = RES_DATA;
        snap  = RES_DATA;
        repeat (ready_delay) begin
            @(negedge CLK);
            if (RES_VALID !== 1'b1 || RES_DATA !== snap || XIN_READY !== 1'b0 || BUSY !== 1'b1)
                j_hold_bad++;
        end
        RES_READY = 1'b1;
        if (poke) begin
            START = 1'b1; NUM_ROWS = 3'd1;
        end
        @(negedge CLK);
        RES_READY = 1'b0; START = 1'b0;
        j_busy_after = BUSY;
        j_rv_after   = RES_VALID;
        @(negedge CLK);
        j_busy_after2 = BUSY;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge CLK);
        n_checks++; if (M_ENCB !== 1'b1)    begin n_fail++; $display("FAIL reset_encb got=%b want=1", M_ENCB); end
        n_checks++; if (M_REB !== 1'b1)     begin n_fail++; $display("FAIL reset_reb got=%b want=1", M_REB); end
        n_checks++; if (M_BANKB !== 4'd0)   begin n_fail++; $display("FAIL reset_bankb got=%h want=0", M_BANKB); end
        n_checks++; if (M_ADRB !== 2'd0)    begin n_fail++; $display("FAIL reset_adrb got=%h want=0", M_ADRB); end
        n_checks++; if (M_XIN !== 176'd0)   begin n_fail++; $display("FAIL reset_xin got=%h want=0", M_XIN); end
        n_checks++; if (XIN_READY !== 1'b0) begin n_fail++; $display("FAIL reset_xin_ready got=%b want=0", XIN_READY); end
        n_checks++; if (BUSY !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got=%b want=0", BUSY); end
        n_checks++; if (ERR !== 1'b0)       begin n_fail++; $display("FAIL reset_err got=%b want=0", ERR); end
        n_checks++; if (RES_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid got=%b want=0", RES_VALID); end
        n_checks++; if (RES_DATA !== 24'd0) begin n_fail++; $display("FAIL reset_res_data got=%h want=0", RES_DATA); end
        NRST = 1'b1;
        @(negedge CLK);
        n_checks++; if (BUSY !== 1'b0 || XIN_READY !== 1'b0)
            begin n_fail++; $display("FAIL idle_after_reset busy=%b xin_ready=%b want=0/0", BUSY, XIN_READY); end
    endtask

    task automatic test_reset_mid_strobe();
        int n;
        q_tab[0] = 22'h000010; q_tab[1] = 22'h000020;
        @(negedge CLK);
        START = 1'b1; NUM_ROWS = 3'd2; BANK_CFG = 4'h5;
        @(negedge CLK);
        START = 1'b0; XIN_VALID = 1'b1; XIN_DATA = xin_pat(0);
        n = 0;
        while (XIN_READY !== 1'b1 && n < 60) begin @(negedge CLK); n++; end
        @(negedge CLK);
        XIN_VALID = 1'b0;
        n_checks++; if (M_ENCB !== 1'b0) begin n_fail++; $display("FAIL strobe_before_reset got=%b want=0", M_ENCB); end
        #2 NRST = 1'b0;
        #1;
        n_checks++; if (M_ENCB !== 1'b1 || M_REB !== 1'b1)
            begin n_fail++; $display("FAIL midreset_strobes encb=%b reb=%b want=1/1", M_ENCB, M_REB); end
        n_checks++; if (BUSY !== 1'b0)      begin n_fail++; $display("FAIL midreset_busy got=%b want=0", BUSY); end
        n_checks++; if (RES_VALID !== 1'b0) begin n_fail++; $display("FAIL midreset_res_valid got=%b want=0", RES_VALID); end
        @(negedge CLK);
        NRST = 1'b1;
        q_tab[0] = 22'h000100; q_tab[1] = 22'h000023;
        run_job(2, 4'h3, 1'b0, 1'b0, 0);
        n_checks++; if (j_res !== 24'h000123) begin n_fail++; $display("FAIL after_reset_job got=%h want=000123", j_res); end
    endtask

    task automatic test_single_row();
        q_tab[0] = 22'h009eb0;
        run_job(1, 4'hA, 1'b0, 1'b0, 0);
        n_checks++; if (j_res !== 24'h009eb0) begin n_fail++; $display("FAIL single_row_data got=%h want=009eb0", j_res); end
        n_checks++; if (j_lat !== 4)          begin n_fail++; $display("FAIL single_row_latency got=%0d want=4", j_lat); end
        n_checks++; if (j_busy_after !== 1'b0 || j_rv_after !== 1'b0)
            begin n_fail++; $display("FAIL single_row_idle busy=%b res_valid=%b want=0/0", j_busy_after, j_rv_after); end
    endtask

    task automatic test_four_rows_neg();
        int s0;
        for (int i = 0; i < 4; i++) q_tab[i] = 22'h3FFFFF;
        s0 = strobe_cnt;
        run_job(4, 4'hC, 1'b0, 1'b0, 0);
        n_checks++; if (j_res !== 24'hFFFFFC) begin n_fail++; $display("FAIL four_neg_data got=%h want=fffffc", j_res); end
        n_checks++; if (strobe_cnt - s0 !== 4) begin n_fail++; $display("FAIL four_neg_strobes got=%0d want=4", strobe_cnt - s0); end
        n_checks++; if (j_busy_bad !== 0) begin n_fail++; $display("FAIL four_neg_busy got=%0d want=0", j_busy_bad); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (adr_log[s0 + i] !== 2'(i))
                begin n_fail++; $display("FAIL adrb_seq idx=%0d got=%0d want=%0d", i, adr_log[s0 + i], i); end
            n_checks++; if (bank_log[s0 + i] !== 4'hC)
                begin n_fail++; $display("FAIL bankb idx=%0d got=%h want=c", i, bank_log[s0 + i]); end
            n_checks++; if (xin_log[s0 + i] !== xin_pat(i))
                begin n_fail++; $display("FAIL m_xin idx=%0d got=%h want=%h", i, xin_log[s0 + i], xin_pat(i)); end
        end
    endtask

    task automatic test_alternating_gaps();
        int s0, h0, b0;
        q_tab[0] = 22'h1FFFFF; q_tab[1] = 22'h200000;
        q_tab[2] = 22'h1FFFFF; q_tab[3] = 22'h200000;
        s0 = strobe_cnt; h0 = hs_cnt; b0 = bad_strobe;
        run_job(4, 4'h1, 1'b1, 1'b0, 0);
        n_checks++; if (j_res !== 24'hFFFFFE) begin n_fail++; $display("FAIL alt_data got=%h want=fffffe", j_res); end
        n_checks++; if (strobe_cnt - s0 !== 4 || hs_cnt - h0 !== 4)
            begin n_fail++; $display("FAIL alt_counts strobes=%0d hs=%0d want=4/4", strobe_cnt - s0, hs_cnt - h0); end
        n_checks++; if (bad_strobe - b0 !== 0)
            begin n_fail++; $display("FAIL alt_unpaired_strobe got=%0d want=0", bad_strobe - b0); end
    endtask

    task automatic test_err_reject();
        int e0;
        e0 = err_cnt;
        @(negedge CLK);
        START = 1'b1; NUM_ROWS = 3'd0;
        @(negedge CLK);
        START = 1'b0;
        n_checks++; if (ERR !== 1'b1)  begin n_fail++; $display("FAIL err_rows0 got=%b want=1", ERR); end
        n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL err_rows0_busy got=%b want=0", BUSY); end
        @(negedge CLK);
        n_checks++; if (ERR !== 1'b0)  begin n_fail++; $display("FAIL err_rows0_pulse got=%b want=0", ERR); end
        START = 1'b1; NUM_ROWS = 3'd5;
        @(negedge CLK);
        START = 1'b0;
        n_checks++; if (ERR !== 1'b1)  begin n_fail++; $display("FAIL err_rows5 got=%b want=1", ERR); end
        @(negedge CLK);
        n_checks++; if (ERR !== 1'b0 || BUSY !== 1'b0)
            begin n_fail++; $display("FAIL err_rows5_after err=%b busy=%b want=0/0", ERR, BUSY); end
        repeat (2) @(negedge CLK);
        n_checks++; if (err_cnt - e0 !== 2) begin n_fail++; $display("FAIL err_pulse_count got=%0d want=2", err_cnt - e0); end
    endtask

    task automatic test_start_ignored();
        int e0;
        e0 = err_cnt;
        q_tab[0] = 22'h000123; q_tab[1] = 22'h000456;
        run_job(2, 4'h7, 1'b0, 1'b1, 0);
        n_checks++; if (j_res !== 24'h000579) begin n_fail++; $display("FAIL ignored_start_data got=%h want=000579", j_res); end
        n_checks++; if (err_cnt - e0 !== 0)   begin n_fail++; $display("FAIL ignored_start_err got=%0d want=0", err_cnt - e0); end
        n_checks++; if (j_busy_after !== 1'b0 || j_busy_after2 !== 1'b0)
            begin n_fail++; $display("FAIL done_start_ignored busy=%b,%b want=0,0", j_busy_after, j_busy_after2); end
    endtask

    task automatic test_done_hold();
        q_tab[0] = 22'h000064; q_tab[1] = 22'h0000C8; q_tab[2] = 22'h3FFFCE;
        run_job(3, 4'h2, 1'b0, 1'b0, 10);
        n_checks++; if (j_res !== 24'h0000FA) begin n_fail++; $display("FAIL hold_data got=%h want=0000fa", j_res); end
        n_checks++; if (j_hold_bad !== 0)     begin n_fail++; $display("FAIL hold_unstable got=%0d want=0", j_hold_bad); end
        n_checks++; if (j_busy_after !== 1'b0 || j_rv_after !== 1'b0)
            begin n_fail++; $display("FAIL hold_release busy=%b res_valid=%b want=0/0", j_busy_after, j_rv_after); end
    endtask

    initial begin
        NRST      = 1'b0;
        START     = 1'b0;
        NUM_ROWS  = 3'd0;
        BANK_CFG  = 4'd0;
        XIN_VALID = 1'b0;
        XIN_DATA  = '0;
        RES_READY = 1'b0;
        for (int i = 0; i < 4; i++) q_tab[i] = 22'h0;

        test_reset();
        test_reset_mid_strobe();
        test_single_row();
        test_four_rows_neg();
        test_alternating_gaps();
        test_err_reject();
        test_start_ignored();
        test_done_hold();

        repeat (2) @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
